// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: PC, single-outstanding imem reads,
// prefetch FIFO with valid/ready output, redirect and HLT/exec control.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              running
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    HALTED
  } state_t;

  typedef struct packed {
    logic [15:0]       word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] tgt, tgt_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              kind, kind_n;
  logic              req_q, req_n;

  entry_t            fifo [DEPTH];
  entry_t            head;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     cnt, cnt_n;

  logic              ctl, ack_v, stall;
  logic              push, pop, clr;
  logic              halt_eff;
  logic [ADDR_W-1:0] tgt_eff;

  assign ctl      = halt | redirect;
  assign ack_v    = req_q & imem_ack;
  assign stall    = req_q & ~imem_ack;
  // newest control request overrides whatever FLUSH was holding
  assign halt_eff = ctl ? halt : kind;
  assign tgt_eff  = ctl ? redirect_pc : tgt;

  assign instr_valid = (cnt != '0);
  assign pop         = instr_valid & instr_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, HALTED: begin
        if (exec) state_n = RUN;
      end
      RUN: begin
        if (ctl) begin
          if (stall) state_n = FLUSH;
          else       state_n = halt ? HALTED : RUN;
        end
      end
      FLUSH: begin
        if (imem_ack) state_n = halt_eff ? HALTED : RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    push   = 1'b0;
    clr    = 1'b0;
    pc_n   = pc;
    tgt_n  = tgt;
    kind_n = kind;
    unique case (1'b1)
      (state == RUN) && ctl: begin
        clr    = 1'b1;
        tgt_n  = redirect_pc;
        kind_n = halt;
        if (!stall) pc_n = redirect_pc;
      end
      (state == RUN) && !ctl && ack_v: begin
        push = 1'b1;
        pc_n = pc + ADDR_W'(1);
      end
      (state == FLUSH): begin
        tgt_n  = tgt_eff;
        kind_n = halt_eff;
        if (imem_ack) pc_n = tgt_eff;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_n  = clr ? '0 : cnt + CW'(push) - CW'(pop);
    req_n  = 1'b0;
    addr_n = pc_n;
    unique case (state_n)
      RUN: begin
        req_n = (cnt_n < CW'(DEPTH));
      end
      FLUSH: begin
        req_n  = 1'b1;
        addr_n = addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc     <= RESET_PC;
      tgt    <= RESET_PC;
      kind   <= 1'b0;
      addr_q <= RESET_PC;
      req_q  <= 1'b0;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      pc     <= pc_n;
      tgt    <= tgt_n;
      kind   <= kind_n;
      addr_q <= addr_n;
      req_q  <= req_n;
      cnt    <= cnt_n;
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= '{word: imem_rdata, pc: pc};
  end

  assign head      = fifo[rd_ptr];
  assign instr     = instr_valid ? head.word : '0;
  assign instr_pc  = instr_valid ? head.pc : '0;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign running   = (state == RUN) || (state == FLUSH);

endmodule
